// File: rtl/pipelined_prefix_adder_if.sv
// Stream bundle for the pipelined prefix adder: operand beat in, result beat out.
// The adder is the slave; whoever feeds operands and drains results is the master.
interface pipelined_prefix_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_x, in_y, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_x, in_y, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready stream handshake.
// Carry-in is folded into bit 0's generate, so the final group generates are the carries.
module pipelined_prefix_adder #(
    parameter int WIDTH      = 8,
    parameter int PIPE_EVERY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    pipelined_prefix_adder_if.slave bus
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int NP     = 1 << LEVELS;

    // One global enable: a stalled output freezes every stage, bubbles included.
    logic advance;
    assign advance      = ~(bus.out_valid & ~bus.out_ready);
    assign bus.in_ready = advance;

    logic             v0;
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] yp0;
    logic             c00;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: only valid bits are reset; stale data behind a cleared valid is never observed.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= 1'b0;
        end else if (advance) begin
            v0  <= bus.in_valid;
            x0  <= bus.in_x;
            yp0 <= bus.in_sub ? ~bus.in_y : bus.in_y;
            c00 <= bus.in_sub ^ bus.in_cin;
        end
    end

    logic [NP-1:0] g0;
    logic [NP-1:0] p0;

    // NOTE: defaults first in every always_comb, so no path leaves a bit unassigned (no latch).
    always_comb begin
        g0             = '0;
        p0             = '0;
        g0[WIDTH-1:0]  = x0 & yp0;
        p0[WIDTH-1:0]  = x0 | yp0;
        g0[0]          = g0[0] | (p0[0] & c00);
    end

    for (genvar k = 0; k < LEVELS; k++) begin : lvl
        localparam int D = 1 << k;

        logic [NP-1:0]    g_in, p_in, g_nx, p_nx, g_out, p_out;
        logic [WIDTH-1:0] h_in, h_out;
        logic             c_in, c_out, v_in, v_out;

        if (k == 0) begin : src
            assign g_in = g0;
            assign p_in = p0;
            assign h_in = x0 ^ yp0;
            assign c_in = c00;
            assign v_in = v0;
        end else begin : src
            assign g_in = lvl[k-1].g_out;
            assign p_in = lvl[k-1].p_out;
            assign h_in = lvl[k-1].h_out;
            assign c_in = lvl[k-1].c_out;
            assign v_in = lvl[k-1].v_out;
        end

        always_comb begin
            g_nx = g_in;
            p_nx = p_in;
            for (int i = D; i < NP; i++) begin
                g_nx[i] = g_in[i] | (p_in[i] & g_in[i-D]);
                p_nx[i] = p_in[i] & p_in[i-D];
            end
        end

        // The last level always feeds the output register directly, never a stage register.
        if ((k <= LEVELS - 2) && (((k + 1) % PIPE_EVERY) == 0)) begin : pipe
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_out <= 1'b0;
                end else if (advance) begin
                    v_out <= v_in;
                    g_out <= g_nx;
                    p_out <= p_nx;
                    h_out <= h_in;
                    c_out <= c_in;
                end
            end
        end else begin : thru
            assign v_out = v_in;
            assign g_out = g_nx;
            assign p_out = p_nx;
            assign h_out = h_in;
            assign c_out = c_in;
        end
    end

    logic [NP-1:0]    g_f;
    logic [NP-1:0]    p_f;
    logic [WIDTH-1:0] h_f;
    logic             c_f;
    logic             v_f;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign g_f   = lvl[LEVELS-1].g_out;
    assign p_f   = lvl[LEVELS-1].p_out;
    assign h_f   = lvl[LEVELS-1].h_out;
    assign c_f   = lvl[LEVELS-1].c_out;
    assign v_f   = lvl[LEVELS-1].v_out;
    assign carry = {g_f[WIDTH-1:0], c_f};
    assign sum   = h_f ^ carry[WIDTH-1:0];

    // Group propagates of the last level and padded generate bits have no consumer.
    logic unused_prefix;
    assign unused_prefix = &{1'b0, p_f, g_f};

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_cout  <= 1'b0;
            bus.out_ovf   <= 1'b0;
            bus.out_zero  <= 1'b0;
        end else if (advance) begin
            bus.out_valid <= v_f;
            if (v_f) begin
                bus.out_sum  <= sum;
                bus.out_cout <= carry[WIDTH];
                bus.out_ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
                bus.out_zero <= (sum == '0);
            end
        end
    end
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed bench for the 8-bit default adder plus a randomized run on a 13-bit, PIPE_EVERY=2 build.
module tb_pipelined_prefix_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_prefix_adder_if #(.WIDTH(8))  a_if ();
    pipelined_prefix_adder_if #(.WIDTH(13)) b_if ();

    pipelined_prefix_adder #(.WIDTH(8), .PIPE_EVERY(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    pipelined_prefix_adder #(.WIDTH(13), .PIPE_EVERY(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    // Result packing: {zero, ovf, cout, sum}.
    logic [10:0] res_a;
    logic [15:0] res_b;
    assign res_a = {a_if.out_zero, a_if.out_ovf, a_if.out_cout, a_if.out_sum};
    assign res_b = {b_if.out_zero, b_if.out_ovf, b_if.out_cout, b_if.out_sum};

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic        cin;
        logic        sub;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs [8];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_b(logic [12:0] x, logic [12:0] y, logic cin, logic sub);
        int          sx, sy, sr, ur;
        logic [12:0] s;
        logic        c, o;
        sx = int'($signed(x));
        sy = int'($signed(y));
        sr = sub ? sx - sy - int'(cin) : sx + sy + int'(cin);
        ur = sub ? int'(x) - int'(y) - int'(cin) : int'(x) + int'(y) + int'(cin);
        s  = ur[12:0];
        c  = sub ? (ur >= 0) : (ur > 8191);
        o  = (sr > 4095) || (sr < -4096);
        return {(s == 13'd0), o, c, s};
    endfunction

    // Send one beat into an empty pipe, measure latency and check the result.
    task automatic single_a(input int idx);
        int lat;
        @(negedge clk);
        a_if.in_valid  = 1'b1;
        a_if.in_x      = vecs[idx].x;
        a_if.in_y      = vecs[idx].y;
        a_if.in_cin    = vecs[idx].cin;
        a_if.in_sub    = vecs[idx].sub;
        a_if.out_ready = 1'b1;
        #1;
        check($sformatf("v%0d_rdy", idx), a_if.in_ready, 1);
        @(posedge clk);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            a_if.in_valid = 1'b0;
            #1;
            if (a_if.out_valid) begin
                lat = i;
                break;
            end
        end
        check($sformatf("v%0d_lat", idx), lat, 4);
        check($sformatf("v%0d_res", idx), res_a, vecs[idx].exp);
        @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          sent, recv, seen, lat;
        logic [10:0] hold;
        logic [15:0] q [$];

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 11'h500};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 11'h280};
        vecs[2] = '{8'h05, 8'h07, 1'b0, 1'b1, 11'h0FE};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 11'h37F};
        vecs[4] = '{8'h10, 8'h0F, 1'b1, 1'b1, 11'h500};
        vecs[5] = '{8'h12, 8'h34, 1'b1, 1'b0, 11'h047};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 11'h700};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 1'b1, 11'h0FF};

        a_if.in_valid = 1'b0; a_if.in_x = '0; a_if.in_y = '0;
        a_if.in_cin = 1'b0; a_if.in_sub = 1'b0; a_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0; b_if.in_x = '0; b_if.in_y = '0;
        b_if.in_cin = 1'b0; b_if.in_sub = 1'b0; b_if.out_ready = 1'b1;

        // Reset for two cycles, then release.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid", a_if.out_valid, 0);
        check("rst_outs", res_a, 0);
        check("rst_ready", a_if.in_ready, 1);

        // Each directed vector alone through an empty pipe.
        for (int v = 0; v < 8; v++) single_a(v);

        // Back-to-back stream with out_ready low for three cycles mid-stream.
        sent = 0;
        recv = 0;
        for (int c = 0; c < 40 && recv < 8; c++) begin
            @(negedge clk);
            a_if.in_valid  = (sent < 8);
            a_if.in_x      = vecs[sent % 8].x;
            a_if.in_y      = vecs[sent % 8].y;
            a_if.in_cin    = vecs[sent % 8].cin;
            a_if.in_sub    = vecs[sent % 8].sub;
            a_if.out_ready = !(c >= 5 && c <= 7);
            #1;
            check($sformatf("s%0d_rdy", c), a_if.in_ready, (c >= 5 && c <= 7) ? 0 : 1);
            if (c == 5) hold = res_a;
            if (c == 6 || c == 7) begin
                check($sformatf("s%0d_hold_v", c), a_if.out_valid, 1);
                check($sformatf("s%0d_hold", c), res_a, hold);
            end
            if (a_if.in_valid && a_if.in_ready) sent++;
            if (a_if.out_valid && a_if.out_ready) begin
                if (recv < 8) check($sformatf("s_beat%0d", recv), res_a, vecs[recv].exp);
                else check("s_extra", 1, 0);
                recv++;
            end
        end
        check("s_count", recv, 8);
        @(negedge clk);
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (a_if.out_valid) seen++;
        end
        check("s_no_dup", seen, 0);

        // Three beats in flight, then reset: none may emerge.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_if.in_valid = 1'b1;
            a_if.in_x     = vecs[i].x;
            a_if.in_y     = vecs[i].y;
            a_if.in_cin   = vecs[i].cin;
            a_if.in_sub   = vecs[i].sub;
            @(posedge clk);
        end
        @(negedge clk);
        a_if.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", a_if.out_valid, 0);
        check("mid_rst_outs", res_a, 0);
        check("mid_rst_ready", a_if.in_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (a_if.out_valid) seen++;
        end
        check("mid_rst_flush", seen, 0);
        single_a(5);

        // 13-bit build: latency on an empty pipe, then random traffic against the model.
        @(negedge clk);
        b_if.in_valid  = 1'b1;
        b_if.in_x      = 13'h0FFF;
        b_if.in_y      = 13'h0001;
        b_if.in_cin    = 1'b0;
        b_if.in_sub    = 1'b0;
        b_if.out_ready = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            b_if.in_valid = 1'b0;
            #1;
            if (b_if.out_valid) begin
                lat = i;
                break;
            end
        end
        check("b_lat", lat, 3);
        check("b_lat_res", res_b, {1'b0, 1'b1, 1'b0, 13'h1000});
        @(posedge clk);

        sent = 0;
        recv = 0;
        for (int c = 0; c < 8000 && recv < 400; c++) begin
            @(negedge clk);
            b_if.in_valid  = (sent < 400) && ($urandom_range(0, 3) != 0);
            b_if.in_x      = 13'($urandom);
            b_if.in_y      = 13'($urandom);
            b_if.in_cin    = 1'($urandom);
            b_if.in_sub    = 1'($urandom);
            b_if.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (b_if.in_valid && b_if.in_ready) begin
                q.push_back(model_b(b_if.in_x, b_if.in_y, b_if.in_cin, b_if.in_sub));
                sent++;
            end
            if (b_if.out_valid && b_if.out_ready) begin
                if (q.size() == 0) check("b_extra", 1, 0);
                else check($sformatf("b_beat%0d", recv), res_b, q.pop_front());
                recv++;
            end
        end
        check("b_count", recv, 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
